// File: rtl/rect_fetch.sv
// Read initiator for a valid/ready BRAM port: turns one (base, len) command into
// len sequential address beats and streams the returned words out in order.
module rect_fetch #(
    parameter int unsigned W_DATA  = 5,
    parameter int unsigned W_ADDR  = 14,
    parameter int unsigned W_LEN   = 8,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W_ADDR-1:0] cmd_base,
    input  logic [W_LEN-1:0]  cmd_len,
    output logic              addr1_valid,
    input  logic              addr1_ready,
    output logic [W_ADDR-1:0] addr1_data,
    input  logic              data1_valid,
    output logic              data1_ready,
    input  logic [W_DATA-1:0] data1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              busy
);
    localparam int unsigned PW = $clog2(MAX_OUT);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              state, state_n;
    logic [W_ADDR-1:0]   base_q, base_n;
    logic [W_LEN-1:0]    len_q, len_n;
    logic [W_LEN-1:0]    issue_cnt, issue_n;
    logic [W_LEN-1:0]    out_cnt, out_cnt_n;
    logic [CW-1:0]       credit, credit_n;
    logic                addr_valid_n;
    logic [W_ADDR-1:0]   addr_data_n;
    logic [CW-1:0]       wr_ptr, rd_ptr;
    logic [W_DATA-1:0]   mem [MAX_OUT];
    logic                fifo_full, fifo_empty, push, pop, issue_hs;

    // Return FIFO status, one extra pointer bit distinguishes full from empty
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign data1_ready = !fifo_full;
    assign out_valid   = !fifo_empty;
    assign out_data    = mem[rd_ptr[PW-1:0]];
    assign out_last    = out_valid && (out_cnt == W_LEN'(len_q - W_LEN'(1)));

    assign push     = data1_valid && data1_ready;
    assign pop      = out_valid && out_ready;
    assign issue_hs = addr1_valid && addr1_ready;

    // Next-state, counters and the registered address beat
    always_comb begin
        state_n      = state;
        base_n       = base_q;
        len_n        = len_q;
        issue_n      = issue_cnt;
        out_cnt_n    = pop ? W_LEN'(out_cnt + W_LEN'(1)) : out_cnt;
        credit_n     = CW'(credit + CW'(issue_hs) - CW'(pop));
        addr_valid_n = addr1_valid;
        addr_data_n  = addr1_data;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    base_n    = cmd_base;
                    len_n     = cmd_len;
                    issue_n   = '0;
                    out_cnt_n = '0;
                    if (cmd_len == '0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n      = S_ISSUE;
                        addr_valid_n = 1'b1;
                        addr_data_n  = cmd_base;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_hs) issue_n = W_LEN'(issue_cnt + W_LEN'(1));
                if (issue_hs && (issue_n == len_q)) begin
                    state_n      = S_DRAIN;
                    addr_valid_n = 1'b0;
                end else if (issue_hs || !addr1_valid) begin
                    // A pending beat is never withdrawn; a new one needs a free credit
                    addr_valid_n = (issue_n < len_q) && (credit_n < CW'(MAX_OUT));
                    addr_data_n  = W_ADDR'(base_q + W_ADDR'(issue_n));
                end
            end
            S_DRAIN: begin
                if (pop && out_last) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            out_cnt     <= '0;
            credit      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            addr1_valid <= 1'b0;
            addr1_data  <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < int'(MAX_OUT); i++) mem[i] <= '0;
        end else begin
            state       <= state_n;
            base_q      <= base_n;
            len_q       <= len_n;
            issue_cnt   <= issue_n;
            out_cnt     <= out_cnt_n;
            credit      <= credit_n;
            addr1_valid <= addr_valid_n;
            addr1_data  <= addr_data_n;
            cmd_ready   <= (state_n == S_IDLE);
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= data1;
                wr_ptr              <= CW'(wr_ptr + CW'(1));
            end
            if (pop) rd_ptr <= CW'(rd_ptr + CW'(1));
        end
    end
endmodule

// File: tb/tb_rect_fetch.sv
// Randomized bench for rect_fetch: a ROM responder plus an in-order command
// reference built from base/len arithmetic.
module tb_rect_fetch;
    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [13:0] cmd_base;
    logic [7:0]  cmd_len;
    logic        addr1_valid, addr1_ready;
    logic [13:0] addr1_data;
    logic        data1_valid, data1_ready;
    logic [4:0]  data1;
    logic        out_valid, out_ready;
    logic [4:0]  out_data;
    logic        out_last, done, busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] rq[$];

    rect_fetch #(.W_DATA(5), .W_ADDR(14), .W_LEN(8), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .addr1_valid(addr1_valid), .addr1_ready(addr1_ready), .addr1_data(addr1_data),
        .data1_valid(data1_valid), .data1_ready(data1_ready), .data1(data1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] rom(input logic [13:0] a);
        logic [13:0] h;
        h = a ^ (a >> 5) ^ (a >> 10) ^ 14'h0015;
        return h[4:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one command to completion (or until abort_at cycles) against the model
    task automatic run_cmd(input logic [13:0] b, input logic [7:0] l, input int stall,
                           input int hold, input int abort_at);
        int          cyc = 0;
        int          fin_cyc = -1;
        int          n_iss = 0;
        int          n_out = 0;
        logic        accepted = 1'b0;
        logic        finished = 1'b0;
        logic        pv = 1'b0;
        logic [13:0] pa = '0;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            cmd_valid   = !accepted;
            cmd_base    = b;
            cmd_len     = l;
            addr1_ready = ($urandom_range(99) >= 32'(stall));
            data1_valid = (rq.size() > 0) && ($urandom_range(99) >= 32'(stall));
            data1       = data1_valid ? rom(rq[0]) : 5'd0;
            out_ready   = (cyc > hold) && ($urandom_range(99) >= 32'(stall));
            #1;
            if (pv) begin
                chk("addr_hold_valid", 32'(addr1_valid), 32'd1);
                chk("addr_hold_data", 32'(addr1_data), 32'(pa));
            end
            pv = addr1_valid && !addr1_ready;
            pa = addr1_data;
            chk("credit_bound", 32'(n_iss - n_out <= MAX_OUT), 32'd1);
            if (l == 8'd0) chk("zero_len_quiet", 32'(addr1_valid | out_valid), 32'd0);
            if (cmd_valid && cmd_ready) begin
                accepted = 1'b1;
                if (l == 8'd0) fin_cyc = cyc;
            end
            if (addr1_valid && addr1_ready) begin
                chk("addr", 32'(addr1_data), 32'(14'(b + 14'(n_iss))));
                n_iss++;
                rq.push_back(addr1_data);
            end
            if (data1_valid && data1_ready) void'(rq.pop_front());
            if (out_valid && out_ready) begin
                chk("data", 32'(out_data), 32'(rom(14'(b + 14'(n_out)))));
                chk("last", 32'(out_last), 32'(n_out == int'(l) - 1));
                n_out++;
                if (n_out == int'(l)) fin_cyc = cyc;
            end
            if (hold > 0 && cyc == hold) begin
                chk("stall_issued", 32'(n_iss), 32'(int'(l) < MAX_OUT ? int'(l) : MAX_OUT));
                chk("stall_addr_idle", 32'(addr1_valid), 32'd0);
            end
            if (done) begin
                chk("done_latency", 32'(cyc), 32'(fin_cyc + 1));
                chk("issued_count", 32'(n_iss), 32'(l));
                chk("out_count", 32'(n_out), 32'(l));
                finished = 1'b1;
            end
            if (abort_at > 0 && cyc == abort_at) return;
            if (cyc > 3000) begin
                chk("timeout", 32'd0, 32'd1);
                finished = 1'b1;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("back_idle", 32'({cmd_ready, busy}), 32'b10);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr_valid"}, 32'(addr1_valid), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_data_ready"}, 32'(data1_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
        addr1_ready = 1'b0; data1_valid = 1'b0; data1 = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        run_cmd(14'h0010, 8'd3, 0, 0, 0);
        run_cmd(14'h0123, 8'd0, 0, 0, 0);
        run_cmd(14'h3FFE, 8'd4, 0, 0, 0);
        run_cmd(14'h0200, 8'd10, 0, 20, 0);

        // Reset with two returned words parked in the FIFO during drain
        run_cmd(14'h0400, 8'd2, 0, 100, 8);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_drain_reset");
        rq.delete();
        cmd_valid = 1'b0; addr1_ready = 1'b0; data1_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_cmd(14'h0777, 8'd5, 0, 0, 0);

        for (int i = 0; i < 100; i++)
            run_cmd(14'($urandom), 8'($urandom_range(20)), 35, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
